// File: rtl/i2c_decode.sv
// ---------------------------------------------------------------------------
// i2c_decode
//
// Bus-condition decoder for the I2C slave datapath. The raw SCL/SDA lines are
// sampled on the system clock and START / STOP conditions are reported as
// single-cycle pulses. The first received byte (address + R/W) is decoded
// into an address-match flag and the transfer direction.
//
// Optional build macro: DECODE_SYNC_EN
//   When defined, a two-flop synchronizer (reset value 1) sits in front of
//   the sampling registers on both scl and sda_in. This adds two cycles of
//   latency to start_found / stop_found. Pulse width and the detection rules
//   do not change.
//
// Parameters:
//   SLAVE_ADDR     7-bit slave address compared against starting_byte[7:1]
//
// Ports:
//   clk            in   system clock, rising-edge active
//   n_rst          in   synchronous reset, active HIGH despite the name
//   scl            in   raw I2C clock line
//   sda_in         in   raw I2C data line
//   starting_byte  in   [7:0] first byte after START ([7:1] addr, [0] R/W)
//   rw_mode        out  1 = master reads from slave, 0 = master writes
//   address_match  out  starting_byte[7:1] == SLAVE_ADDR
//   stop_found     out  one-cycle pulse on a STOP condition
//   start_found    out  one-cycle pulse on a START / repeated START
// ---------------------------------------------------------------------------
module i2c_decode #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       scl,
   input  logic       sda_in,
   input  logic [7:0] starting_byte,
   output logic       rw_mode,
   output logic       address_match,
   output logic       stop_found,
   output logic       start_found
);

   // Line values presented to the sampling registers.
   logic scl_line;
   logic sda_line;

`ifdef DECODE_SYNC_EN
   // Two-flop synchronizers. Reset to the idle-bus level so that coming out
   // of reset does not look like a line transition.
   logic [1:0] scl_sync_q;
   logic [1:0] scl_sync_d;
   logic [1:0] sda_sync_q;
   logic [1:0] sda_sync_d;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl};
      sda_sync_d = {sda_sync_q[0], sda_in};
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
      end
   end

   assign scl_line = scl_sync_q[1];
   assign sda_line = sda_sync_q[1];
`else
   assign scl_line = scl;
   assign sda_line = sda_in;
`endif

   // Sampling registers: current and previous sample of each line.
   logic scl_cur_q;
   logic scl_cur_d;
   logic sda_cur_q;
   logic sda_cur_d;
   logic scl_prev_q;
   logic scl_prev_d;
   logic sda_prev_q;
   logic sda_prev_d;

   always_comb begin
      scl_cur_d  = scl_line;
      sda_cur_d  = sda_line;
      scl_prev_d = scl_cur_q;
      sda_prev_d = sda_cur_q;
   end

   // All four reset to 1 (idle bus), which discards any edge that was in
   // flight when reset arrived.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         scl_cur_q  <= 1'b1;
         sda_cur_q  <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_cur_q  <= scl_cur_d;
         sda_cur_q  <= sda_cur_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   // SCL must be high in both samples; SDA direction selects START or STOP.
   // The two are mutually exclusive because they need opposite SDA edges.
   assign start_found = scl_prev_q & scl_cur_q &  sda_prev_q & ~sda_cur_q;
   assign stop_found  = scl_prev_q & scl_cur_q & ~sda_prev_q &  sda_cur_q;

   // Address/direction decode is purely combinational and ignores reset.
   assign rw_mode       = starting_byte[0];
   assign address_match = (starting_byte[7:1] == SLAVE_ADDR);

endmodule

// File: tb/tb_i2c_decode.sv
// ---------------------------------------------------------------------------
// tb_i2c_decode
//
// Self-checking bench for i2c_decode. A table of per-cycle records holds the
// inputs applied before a rising edge and the outputs expected just after
// it; hand-written sequences then measure START latency and pulse width and
// check that the address decode responds without a clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_decode;

   logic       clk;
   logic       n_rst;
   logic       scl;
   logic       sda_in;
   logic [7:0] starting_byte;
   logic       rw_mode;
   logic       address_match;
   logic       stop_found;
   logic       start_found;

`ifdef DECODE_SYNC_EN
   localparam int EXP_LAT = 3;
`else
   localparam int EXP_LAT = 1;
`endif

   i2c_decode dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .scl           (scl),
      .sda_in        (sda_in),
      .starting_byte (starting_byte),
      .rw_mode       (rw_mode),
      .address_match (address_match),
      .stop_found    (stop_found),
      .start_found   (start_found)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int idx, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst;
      logic       scl;
      logic       sda;
      logic [7:0] sbyte;
      logic       exp_start;
      logic       exp_stop;
      logic       exp_match;
      logic       exp_rw;
   } vec_t;

   vec_t vecs[$];

   // Address patterns cycled across the table rows, with hand-decoded results.
   logic [7:0] addr_byte [6];
   logic       addr_match[6];
   logic       addr_rw   [6];

   task automatic add(input logic r, input logic c, input logic d,
                      input logic es, input logic ep);
      vec_t v;
      int   k;
      k = vecs.size() % 6;
      v.rst       = r;
      v.scl       = c;
      v.sda       = d;
      v.sbyte     = addr_byte[k];
      v.exp_start = es;
      v.exp_stop  = ep;
      v.exp_match = addr_match[k];
      v.exp_rw    = addr_rw[k];
      vecs.push_back(v);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int width;
      bit seen;
      bit stop_seen;

      addr_byte[0] = 8'hF0; addr_match[0] = 1'b1; addr_rw[0] = 1'b0;
      addr_byte[1] = 8'hF1; addr_match[1] = 1'b1; addr_rw[1] = 1'b1;
      addr_byte[2] = 8'hF3; addr_match[2] = 1'b0; addr_rw[2] = 1'b1;
      addr_byte[3] = 8'h01; addr_match[3] = 1'b0; addr_rw[3] = 1'b1;
      addr_byte[4] = 8'h80; addr_match[4] = 1'b0; addr_rw[4] = 1'b0;
      addr_byte[5] = 8'hF2; addr_match[5] = 1'b0; addr_rw[5] = 1'b0;

      n_rst = 1'b1; scl = 1'b1; sda_in = 1'b0; starting_byte = 8'h00;

      if (EXP_LAT == 1) begin
         //   rst scl sda start stop
         // Reset held with a bus sitting in START, then release.
         add(1, 1, 0, 0, 0);
         add(1, 1, 0, 0, 0);
         add(0, 1, 0, 1, 0);   // forced previous sample = 1 -> START seen
         add(0, 1, 0, 0, 0);   // exactly one cycle wide
         // STOP, START, STOP with lines held between.
         add(0, 1, 1, 0, 1);
         add(0, 1, 1, 0, 0);
         add(0, 1, 0, 1, 0);
         add(0, 1, 0, 0, 0);
         add(0, 1, 1, 0, 1);
         add(0, 1, 1, 0, 0);
         // Data toggling while SCL is low.
         add(0, 0, 1, 0, 0);
         add(0, 0, 0, 0, 0);
         add(0, 0, 1, 0, 0);
         add(0, 0, 0, 0, 0);
         add(0, 1, 0, 0, 0);   // SCL rises, SDA steady low
         add(0, 1, 0, 0, 0);
         // SCL rising and SDA falling on the same sample.
         add(0, 0, 1, 0, 0);
         add(0, 0, 1, 0, 0);
         add(0, 1, 0, 0, 0);
         add(0, 1, 0, 0, 0);
         add(0, 1, 1, 0, 1);
         add(0, 1, 1, 0, 0);
         // SDA falls on the same edge that reset is sampled.
         add(1, 1, 0, 0, 0);
         add(1, 1, 0, 0, 0);
         add(0, 1, 1, 0, 0);   // pending edge discarded
         add(0, 1, 1, 0, 0);
         // Reset arriving on the edge that would have shown a STOP.
         add(0, 1, 0, 1, 0);
         add(1, 1, 1, 0, 0);
         add(0, 1, 1, 0, 0);
         add(0, 1, 1, 0, 0);
      end else begin
         // With the synchronizer the flag timing shifts; the table keeps
         // only reset-quiet rows and the latency is checked by hand below.
         add(1, 1, 1, 0, 0);
         add(1, 1, 1, 0, 0);
         add(0, 1, 1, 0, 0);
         add(0, 1, 1, 0, 0);
         add(0, 1, 1, 0, 0);
         add(0, 1, 1, 0, 0);
      end

      // Inputs change 1 ns after a rising edge; outputs are read 1 ns after.
      @(posedge clk); #1;
      for (int i = 0; i < vecs.size(); i++) begin
         n_rst         = vecs[i].rst;
         scl           = vecs[i].scl;
         sda_in        = vecs[i].sda;
         starting_byte = vecs[i].sbyte;
         @(posedge clk); #1;
         check("start_found",   i, start_found,   vecs[i].exp_start);
         check("stop_found",    i, stop_found,    vecs[i].exp_stop);
         check("address_match", i, address_match, vecs[i].exp_match);
         check("rw_mode",       i, rw_mode,       vecs[i].exp_rw);
      end

      // ---- START latency and width measured against a cycle budget ----
      n_rst = 1'b0; scl = 1'b1; sda_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("idle_start", 0, start_found, 1'b0);
      sda_in = 1'b0;
      lat = 0; seen = 1'b0; stop_seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(posedge clk); #1;
         lat++;
         if (start_found) seen = 1'b1;
      end
      check("start_timeout", 0, seen, 1'b1);
      n_cmp++;
      if (lat != EXP_LAT) begin
         n_err++;
         $display("FAIL start_latency: got %0d cycles expected %0d", lat, EXP_LAT);
      end
      width = 0;
      for (int c = 0; c < 8 && start_found; c++) begin
         width++;
         if (stop_found) stop_seen = 1'b1;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (width != 1) begin
         n_err++;
         $display("FAIL start_width: got %0d cycles expected 1", width);
      end
      check("stop_during_start", 0, stop_seen, 1'b0);

      // ---- STOP width under the same budget ----
      sda_in = 1'b1;
      seen = 1'b0; width = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (stop_found) begin
            seen = 1'b1;
            width++;
         end
      end
      check("stop_timeout", 0, seen, 1'b1);
      n_cmp++;
      if (width != 1) begin
         n_err++;
         $display("FAIL stop_width: got %0d cycles expected 1", width);
      end

      // ---- Address decode reacts with no clock edge and under reset ----
      n_rst = 1'b1;
      @(negedge clk);
      starting_byte = 8'hF1; #1;
      check("async_match_F1", 0, address_match, 1'b1);
      check("async_rw_F1",    0, rw_mode,       1'b1);
      starting_byte = 8'h70; #1;
      check("async_match_70", 0, address_match, 1'b0);
      check("async_rw_70",    0, rw_mode,       1'b0);
      @(posedge clk); #1;
      n_rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
